// File: rtl/display_arbiter.sv
// Round-robin owner of the two-digit seven-segment display.
// Optional leading-zero blanking: DISPLAY_ARBITER_LEADING_ZERO_BLANK_EN.
module display_arbiter #(
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Req_0,
  input  logic [7:0] i_Data_0,
  input  logic       i_Req_1,
  input  logic [7:0] i_Data_1,
  output logic       o_Grant_0,
  output logic       o_Grant_1,
  output logic       o_Owner,
  output logic       o_Busy,
  output logic [3:0] o_Digit1_Bin,
  output logic [3:0] o_Digit2_Bin,
  output logic       o_Digit1_En,
  output logic       o_Digit2_En
);

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic            g0_q, g0_d;
  logic            g1_q, g1_d;
  logic [7:0]      byte_q, byte_d;
  logic            any_req;
  logic            win;

  // Winner is 1 when only 1 asks, or both ask and 1 is favoured.
  always_comb begin
    any_req = i_Req_0 | i_Req_1;
    win     = i_Req_1 & (~i_Req_0 | ptr_q);
  end

  // Next-state: arbitrate in IDLE, count out the dwell in SHOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    byte_d  = byte_q;
    g0_d    = 1'b0;
    g1_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          byte_d  = win ? i_Data_1 : i_Data_0;
          owner_d = win;
          g0_d    = ~win;
          g1_d    = win;
          valid_d = 1'b1;
          cnt_d   = '0;
          ptr_d   = ~win;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and display registers; reset blanks everything at once.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      byte_q  <= 8'h00;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      byte_q  <= byte_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
    end
  end

  assign o_Grant_0    = g0_q;
  assign o_Grant_1    = g1_q;
  assign o_Owner      = owner_q;
  assign o_Busy       = (state_q == SHOW);
  assign o_Digit1_Bin = byte_q[7:4];
  assign o_Digit2_Bin = byte_q[3:0];
  assign o_Digit2_En  = valid_q;

`ifdef DISPLAY_ARBITER_LEADING_ZERO_BLANK_EN
  assign o_Digit1_En  = valid_q & (byte_q[7:4] != 4'h0);
`else
  assign o_Digit1_En  = valid_q;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with HOLD_CYCLES=4.
// Expected grants are queued at stimulus time, popped on grant pulses.
module tb_display_arbiter;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
  logic       g0, g1, owner, busy, e1, e2;
  logic [3:0] d1, d2;

  typedef struct packed {
    logic       who;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  display_arbiter #(.HOLD_CYCLES(4)) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .i_Req_0(req0),
    .i_Data_0(dat0),
    .i_Req_1(req1),
    .i_Data_1(dat1),
    .o_Grant_0(g0),
    .o_Grant_1(g1),
    .o_Owner(owner),
    .o_Busy(busy),
    .o_Digit1_Bin(d1),
    .o_Digit2_Bin(d2),
    .o_Digit1_En(e1),
    .o_Digit2_En(e2)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(logic who, logic [7:0] b);
    exp_t e;
    e.who = who;
    e.b   = b;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(g0 || g1) && n < 40);
    if (!(g0 || g1)) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Grant monitor: pop the scoreboard on every grant pulse.
  always @(negedge clk) begin
    exp_t e;
    if (g0 && g1) check("both_grants", 1, 0);
    if (g0 || g1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_owner", owner, e.who);
        check("sb_grant1", g1, e.who);
        check("sb_byte", {d1, d2}, e.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fall, gnt, bad;

    // Reset then single request
    step();
    check("rst_outs", {g0, g1, owner, busy, d1, d2, e1, e2}, 0);
    step();
    step();
    rst_l = 1'b1;
    req0 = 1'b1;
    dat0 = 8'h3C;
    push(1'b0, 8'h3C);
    wait_grant(n);
    check("s1_lat", n, 1);
    check("s1_g0", g0, 1);
    check("s1_busy0", busy, 1);
    check("s1_digits", {d1, d2}, 8'h3C);
    check("s1_owner", owner, 0);
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s1_pulse", g0, 0);
      check("s1_busy", busy, 1);
    end
    step();
    check("s1_busy_low", busy, 0);
    step();
    check("s1_idle", busy, 0);

    // Simultaneous contention from a fresh pointer
    #2 rst_l = 1'b0;
    step();
    step();
    rst_l = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    dat0 = 8'h11;
    dat1 = 8'h22;
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    wait_grant(n);
    check("s2_first", n, 1);
    for (int k = 0; k < 3; k++) begin
      wait_grant(n);
      check("s2_spacing", n, 5);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Request raised during SHOW
    wait_idle();
    req0 = 1'b1;
    dat0 = 8'h5A;
    push(1'b0, 8'h5A);
    wait_grant(n);
    req0 = 1'b0;
    step();
    req1 = 1'b1;
    dat1 = 8'h66;
    push(1'b1, 8'h66);
    fall = -1;
    gnt = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!busy && fall < 0) fall = i;
      if (g1 && gnt < 0) begin
        gnt = i;
        req1 = 1'b0;
      end
    end
    check("s3_gap", gnt - fall, 1);
    check("s3_fall", fall, 3);

    // Idle persistence
    wait_idle();
    req0 = 1'b1;
    dat0 = 8'hA7;
    push(1'b0, 8'hA7);
    wait_grant(n);
    req0 = 1'b0;
    wait_idle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({d1, d2} != 8'hA7 || !e1 || !e2 || busy) bad = 1;
    end
    check("s4_hold", bad, 0);
    check("s4_digits", {d1, d2}, 8'hA7);
    check("s4_en", {e1, e2}, 2'b11);

    // Reset mid-dwell
    req0 = 1'b1;
    dat0 = 8'h99;
    push(1'b0, 8'h99);
    wait_grant(n);
    req0 = 1'b0;
    step();
    step();
    check("s5_busy", busy, 1);
    #2 rst_l = 1'b0;
    #1 check("s5_outs",
             {g0, g1, owner, busy, d1, d2, e1, e2}, 0);
    step();
    step();
    rst_l = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    dat0 = 8'h11;
    dat1 = 8'h22;
    push(1'b0, 8'h11);
    wait_grant(n);
    check("s5_winner", {g0, g1, owner}, 3'b100);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();

    // Leading-zero blanking, 0x05 then 0x00
    req0 = 1'b1;
    dat0 = 8'h05;
    push(1'b0, 8'h05);
    wait_grant(n);
    req0 = 1'b0;
`ifdef DISPLAY_ARBITER_LEADING_ZERO_BLANK_EN
    check("s6_en05", {e1, e2}, 2'b01);
`else
    check("s6_en05", {e1, e2}, 2'b11);
`endif
    wait_idle();
    req0 = 1'b1;
    dat0 = 8'h00;
    push(1'b0, 8'h00);
    wait_grant(n);
    req0 = 1'b0;
`ifdef DISPLAY_ARBITER_LEADING_ZERO_BLANK_EN
    check("s7_en00", {e1, e2}, 2'b01);
`else
    check("s7_en00", {e1, e2}, 2'b11);
`endif
    wait_idle();
    step();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the board's two-digit seven-segment display between two requesters, for example a UART receive byte and a switch-driven counter. Each requester presents an 8-bit value and a request. The block grants the display round-robin, latches the winning byte, and holds it on screen for a minimum dwell time. It outputs the upper and lower nibbles plus per-digit enables, which feed two binary-to-seven-segment converter instances.

## Interface
- HOLD_CYCLES, 25000000, dwell time per grant in clock cycles (1 s at 25 MHz); legal range ≥ 1
- i_Clk  input  1  system clock; all logic on its rising edge
- i_Rst_L  input  1  reset, asynchronous assert, active-low
- i_Req_0  input  1  requester 0 wants the display (level)
- i_Data_0  input  8  requester 0 byte, sampled on the grant edge
- i_Req_1  input  1  requester 1 wants the display (level)
- i_Data_1  input  8  requester 1 byte, sampled on the grant edge
- o_Grant_0  output  1  one-cycle pulse: i_Data_0 captured
- o_Grant_1  output  1  one-cycle pulse: i_Data_1 captured
- o_Owner  output  1  requester whose byte is displayed
- o_Busy  output  1  dwell in progress (SHOW state)
- o_Digit1_Bin  output  4  upper nibble of displayed byte
- o_Digit2_Bin  output  4  lower nibble of displayed byte
- o_Digit1_En  output  1  upper digit lit
- o_Digit2_En  output  1  lower digit lit

## Operation
- **Reset values.** While i_Rst_L=0, every output is 0 (both digits blank). The state is IDLE, the hold counter is 0, the display-valid flag is 0, and the priority pointer favours requester 0.
- **States.** There are two states, IDLE and SHOW.
- **IDLE.** At a clock edge with any request high, the block:
  - picks the winner;
  - latches its byte into the digit registers;
  - sets o_Owner to the winner;
  - pulses that requester's grant;
  - sets the display-valid flag;
  - clears the counter;
  - moves to SHOW.
  With no request, it stays in IDLE and the displayed value is unchanged.
- **Arbitration.** With a single request, that requester wins. With both high, the requester not granted last time wins. The pointer updates on every grant.
- **SHOW.** The counter increments every cycle. When the counter reaches HOLD_CYCLES-1, the block returns to IDLE. Requests are ignored while in SHOW.
- **Request rule.** A requester holds its request and data stable until its grant pulse. A request still high after the grant competes again at the next arbitration.
- **Counter.** Width is $clog2(HOLD_CYCLES), with a minimum of 1. No wrap occurs because the counter is cleared on each grant.
- **Digit enables.** Both enables are 0 until the first grant. Once the display-valid flag is set, the enables follow the Configuration section.
- **Reset mid-dwell.** Asserting reset during SHOW blanks the display immediately and discards the latched byte.

## Timing
- **Grant latency.** The grant, digit, owner and busy outputs change at the first rising edge at which the request is sampled high in IDLE. Latency is 0 cycles after that edge, 1 cycle from a request asserted mid-cycle. All outputs are registered.
- **Grant pulse.** Each grant pulse is exactly 1 cycle wide. o_Grant_0 and o_Grant_1 are never high together.
- **Busy.** o_Busy is high for exactly HOLD_CYCLES cycles starting with the grant cycle.
- **Minimum grant spacing.** At least one IDLE cycle follows each SHOW. Grant-to-grant spacing is at least HOLD_CYCLES+1 cycles, and exactly that under continuous requests.
- **Persistence.** Digit outputs hold their value through IDLE until the next grant.
- **Reset release.** Reset is deasserted asynchronously. The first arbitration happens at the first edge after release.

## Configuration
- The feature is controlled by the macro DISPLAY_ARBITER_LEADING_ZERO_BLANK_EN.
- **Defined.**
  - o_Digit1_En = valid AND (o_Digit1_Bin ≠ 0).
  - o_Digit2_En = valid.
  - So byte 0x05 shows as a single digit and 0x00 shows as "0".
- **Undefined.** o_Digit1_En = o_Digit2_En = valid; both digits are always lit after the first grant.
- Arbitration and timing are identical in both builds.

## Test plan
All scenarios use HOLD_CYCLES=4.
- **Reset then single request.** Reset low for 3 cycles, then raise i_Req_0 with i_Data_0=0x3C. Required response:
  - o_Grant_0 is a 1-cycle pulse;
  - digits are 3/C, o_Owner=0;
  - o_Busy is high for 4 cycles, then low for 1 cycle.
- **Simultaneous contention.** Hold both requests continuously with i_Data_0=0x11 and i_Data_1=0x22. Required response:
  - grants alternate 0,1,0,1, with pulses 5 cycles apart;
  - the displayed byte alternates 0x11/0x22.
- **Request during SHOW.** Raise i_Req_1 on the 2nd cycle of requester 0's dwell. Required response: o_Grant_1 occurs exactly 1 cycle after o_Busy falls, and no earlier.
- **Idle persistence.** After a single grant of 0xA7, drop all requests for 20 cycles. Required response: digits stay A/7, both enables stay 1, and o_Busy stays 0.
- **Reset mid-dwell.** Pull i_Rst_L low on the 3rd SHOW cycle, without a clock edge. Required response:
  - all outputs go to 0 at once;
  - after release, the first contended grant goes to requester 0.
- **Leading-zero blanking, 0x05.**
  - With the macro defined: o_Digit1_En=0 and o_Digit2_En=1.
  - Without the macro: both enables are 1.
- **Leading-zero blanking, 0x00.** With the macro defined: o_Digit1_En=0 and o_Digit2_En=1.
